sum: RTL and testbench
======================

Name: sum

Overview:
- Sum-generation stage of a carry-lookahead adder.
- Per bit i: sum bit z[i] = p[i] XOR c[i], where p is propagate, g is generate and c is the carry into bit i, all supplied by the upstream lookahead logic.
- Also produces the stage carry-out from the MSB.
- Results are registered: one-cycle latency with a valid qualifier, placed directly after the carry-lookahead block.

Parameters:
- WIDTH, 1, number of bit slices (p/g/c/z width); legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  p/g/c are valid this cycle.
- p  input  WIDTH  per-bit propagate (a XOR b).
- g  input  WIDTH  per-bit generate (a AND b).
- c  input  WIDTH  per-bit carry-in from lookahead logic; c[0] is the adder carry-in.
- z  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out = g[WIDTH-1] | (p[WIDTH-1] & c[WIDTH-1]).
- out_valid  output  1  z/cout hold a valid result.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk with rst=1, z, cout and out_valid all go to 0 (and err to 0 when present). rst has priority over in_valid.
- Capture, in_valid=1 at edge N: after edge N, z = p ^ c and cout per the formula above, both computed from the inputs sampled at edge N; out_valid=1.
- Idle, in_valid=0 at an edge: out_valid goes to 0; z and cout hold their previous values.
- Latency is exactly 1 cycle. No backpressure: back-to-back valid inputs produce back-to-back outputs.
- g does not affect z. g affects only cout (and err when present).
- Bitwise and fully independent per slice: no internal carry chain, no overflow or wrap concerns.
- WIDTH=1 degenerates to a single-bit sum cell with a carry-out.
- p=1 with g=1 on the same bit is not a legal adder encoding. It is still processed: z[i] = 1 ^ c[i] and cout as per formula.
- Reset asserted mid-stream discards the in-flight result. The first valid output after reset release appears one cycle after the first in_valid.
- Inputs that are X/Z while in_valid=0 must not corrupt the held z/cout.

Optional Feature:
- Macro: SUM_PG_CHECK_EN.
- When defined: adds output port err (1 bit), registered and reset to 0. At an edge with in_valid=1, err is set to 1 when any bit has p[i]&g[i]=1, otherwise 0. With in_valid=0, err goes to 0.
- When undefined: no err port and no check logic. All other behaviour is identical.

Decomposition:
- Shared package sum_pkg holds: the localparam for maximum WIDTH (64), and the function computing the MSB carry-out from (g, p, c) bits, reused by the lookahead block.
- One natural sub-module, sum_bit: the combinational per-slice cell z = p ^ c, instantiated WIDTH times via generate. Register stage and valid logic live in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs and in_valid=1 -> z=0, cout=0, out_valid=0 throughout; first result appears 1 cycle after release.
- WIDTH=1 exhaustive, in_valid=1, all eight (p,g,c) combinations 000..111 in order:
  - z = 0,1,0,1,1,0,1,0.
  - cout = 0,0,1,1,0,1,1,1.
  - each one cycle after its input.
- WIDTH=4, in_valid=1: p=4'b1010, g=4'b0101, c=4'b0110 -> next cycle z=4'b1100, cout=0 (g3=0, p3&c3=0).
- Hold: valid vector then in_valid=0 with p=4'hF, c=4'h0 -> out_valid=0, z unchanged from the prior result.
- Back-to-back: three consecutive valid vectors -> three consecutive out_valid=1 cycles with matching z.
- With SUM_PG_CHECK_EN: p=1, g=1, c=0, in_valid=1 -> next cycle err=1, z=1, cout=1; then p=1, g=0 -> err=0.

Source files
------------

// File: rtl/sum_pkg.sv
// sum_pkg: shared width limit and carry-out helper for the sum stage
package sum_pkg;
  localparam int MAX_WIDTH = 64;
  function automatic logic carry_out(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction
endpackage

// File: rtl/sum_if.sv
// sum_if: lookahead-to-sum bus; err member exists only with SUM_PG_CHECK_EN
interface sum_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             out_valid;
`ifdef SUM_PG_CHECK_EN
  logic             err;
  modport master (output in_valid, p, g, c, input z, cout, out_valid, err);
  modport slave  (input in_valid, p, g, c, output z, cout, out_valid, err);
`else
  modport master (output in_valid, p, g, c, input z, cout, out_valid);
  modport slave  (input in_valid, p, g, c, output z, cout, out_valid);
`endif
endinterface

// File: rtl/sum_bit.sv
// sum_bit: one combinational sum slice, z = p ^ c
module sum_bit (
  input  logic i_p,
  input  logic i_c,
  output logic o_z
);
  assign o_z = i_p ^ i_c;
endmodule

// File: rtl/sum.sv
// sum: registered sum stage of a carry-lookahead adder (optional p&g check under SUM_PG_CHECK_EN)
module sum
  import sum_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic clk,
  input logic rst,
  sum_if.slave bus
);
  logic [WIDTH-1:0] w_z;
  logic             w_cout;
  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_valid;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sum_bit u_bit (
      .i_p(bus.p[i]),
      .i_c(bus.c[i]),
      .o_z(w_z[i])
    );
  end
  assign w_cout = carry_out(bus.g[WIDTH-1], bus.p[WIDTH-1], bus.c[WIDTH-1]);
  // result register: load only on valid so idle (possibly unknown) inputs never disturb held data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z     <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_z    <= w_z;
        r_cout <= w_cout;
      end
    end
  end
  assign bus.z         = r_z;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_valid;
`ifdef SUM_PG_CHECK_EN
  logic r_err;
  // flag an illegal p&g encoding on any slice of a valid input; cleared on idle cycles
  always_ff @(posedge clk) begin
    r_err <= rst ? 1'b0 : (bus.in_valid ? |(bus.p & bus.g) : 1'b0);
  end
  assign bus.err = r_err;
`endif
endmodule

// File: tb/tb_sum.sv
// tb_sum: scoreboard bench for sum at WIDTH=1 and WIDTH=4 (SUM_PG_CHECK_EN adds err checks)
module tb_sum;
  typedef struct {
    logic [3:0] z;
    logic       cout;
    logic       err;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  logic r1, v1, r4, v4;
  logic [3:0] h1z, h4z;
  logic h1c, h4c;
  sum_if #(.WIDTH(1)) b1 ();
  sum_if #(.WIDTH(4)) b4 ();
  sum #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(b1));
  sum #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(b4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask
  always @(posedge clk) begin
    r1 = rst;
    v1 = b1.in_valid;
    if (r1) q1.delete();
    else if (v1) q1.push_back('{z: {3'b000, b1.p[0] ^ b1.c[0]},
                                cout: b1.g[0] | (b1.p[0] & b1.c[0]),
                                err: b1.p[0] & b1.g[0]});
    #1;
    if (r1) begin
      chk("w1_rst_valid", b1.out_valid, 0);
      chk("w1_rst_z", b1.z, 0);
      chk("w1_rst_cout", b1.cout, 0);
      h1z = 0;
      h1c = 0;
`ifdef SUM_PG_CHECK_EN
      chk("w1_rst_err", b1.err, 0);
`endif
    end else if (v1) begin
      chk("w1_valid", b1.out_valid, 1);
      if (q1.size() == 0) chk("w1_queue", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("w1_z", b1.z, e1.z);
        chk("w1_cout", b1.cout, e1.cout);
        h1z = e1.z;
        h1c = e1.cout;
`ifdef SUM_PG_CHECK_EN
        chk("w1_err", b1.err, e1.err);
`endif
      end
    end else begin
      chk("w1_idle_valid", b1.out_valid, 0);
      chk("w1_hold_z", b1.z, h1z);
      chk("w1_hold_cout", b1.cout, h1c);
`ifdef SUM_PG_CHECK_EN
      chk("w1_idle_err", b1.err, 0);
`endif
    end
  end
  always @(posedge clk) begin
    r4 = rst;
    v4 = b4.in_valid;
    if (r4) q4.delete();
    else if (v4) q4.push_back('{z: b4.p ^ b4.c,
                                cout: b4.g[3] | (b4.p[3] & b4.c[3]),
                                err: |(b4.p & b4.g)});
    #1;
    if (r4) begin
      chk("w4_rst_valid", b4.out_valid, 0);
      chk("w4_rst_z", b4.z, 0);
      chk("w4_rst_cout", b4.cout, 0);
      h4z = 0;
      h4c = 0;
`ifdef SUM_PG_CHECK_EN
      chk("w4_rst_err", b4.err, 0);
`endif
    end else if (v4) begin
      chk("w4_valid", b4.out_valid, 1);
      if (q4.size() == 0) chk("w4_queue", q4.size(), 1);
      else begin
        e4 = q4.pop_front();
        chk("w4_z", b4.z, e4.z);
        chk("w4_cout", b4.cout, e4.cout);
        h4z = e4.z;
        h4c = e4.cout;
`ifdef SUM_PG_CHECK_EN
        chk("w4_err", b4.err, e4.err);
`endif
      end
    end else begin
      chk("w4_idle_valid", b4.out_valid, 0);
      chk("w4_hold_z", b4.z, h4z);
      chk("w4_hold_cout", b4.cout, h4c);
`ifdef SUM_PG_CHECK_EN
      chk("w4_idle_err", b4.err, 0);
`endif
    end
  end
  task automatic drive(input logic r, input logic v, input logic [3:0] p, input logic [3:0] g, input logic [3:0] c);
    @(negedge clk);
    rst         = r;
    b1.in_valid = v;
    b1.p        = p[0];
    b1.g        = g[0];
    b1.c        = c[0];
    b4.in_valid = v;
    b4.p        = p;
    b4.g        = g;
    b4.c        = c;
  endtask
  task automatic drive_rand(input logic r, input logic v);
    drive(r, v, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask
  initial begin
    logic [2:0] k;
    rst         = 1'b1;
    b1.in_valid = 1'b0;
    b4.in_valid = 1'b0;
    b1.p = '0; b1.g = '0; b1.c = '0;
    b4.p = '0; b4.g = '0; b4.c = '0;
    drive_rand(1, 1);
    drive_rand(1, 1);
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      drive(0, 1, {3'b000, k[2]}, {3'b000, k[1]}, {3'b000, k[0]});
    end
    drive(0, 1, 4'b1010, 4'b0101, 4'b0110);
    drive(0, 0, 4'hF, 4'h0, 4'h0);
    drive(0, 0, 4'hF, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) drive_rand(0, 1);
    drive(0, 1, 4'b0001, 4'b0001, 4'b0000);
    drive(0, 1, 4'b0001, 4'b0000, 4'b0000);
    drive(0, 1, 4'b1000, 4'b1000, 4'b0000);
    drive_rand(0, 0);
    drive_rand(0, 1);
    drive_rand(1, 1);
    drive_rand(0, 0);
    drive_rand(0, 1);
    drive_rand(0, 1);
    for (int i = 0; i < 60; i++) drive_rand(0, 1'($urandom));
    drive_rand(0, 0);
    drive_rand(0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
